beam_steer_ctrl: RTL and testbench
==================================

# beam_steer_ctrl

Sequencing controller for the 16-channel microphone delay datapath. It accepts a steering-angle request, or auto-scans through angles. For each angle it fetches the 16 per-mic delay values from an external coefficient table into a shadow bank. It then commits the whole bank atomically on a PCM sample boundary, so the delay lines never see a mixed set of delays within one sample. It sits between the host/scan logic and the per-mic delay lines, and drives their delay inputs.

## Interface
- NUM_MICS, 16, number of microphone channels / delay lines
- DELAY_W, 5, width of one delay value (in samples)
- MAX_DELAY, 19, largest legal delay; delay-line depth minus one
- SEL_W, 5, width of angle index
- NUM_ANGLES, 32, number of table entries per mic; scan wraps at NUM_ANGLES-1
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- sample_strobe  in  1  one-cycle pulse marking a PCM sample boundary
- sel_valid  in  1  steering request valid
- sel_angle  in  SEL_W  requested angle index, sampled when sel_valid & sel_ready
- sel_ready  out  1  high exactly when FSM is IDLE
- scan_en  in  1  enable auto-scan
- dwell  in  16  samples per angle in scan mode; 0 treated as 1
- tbl_rd_en  out  1  coefficient table read strobe
- tbl_addr  out  SEL_W+4  read address = angle*NUM_MICS + mic
- tbl_rd_data  in  DELAY_W  table data, valid exactly 1 cycle after tbl_rd_en
- delay_flat  out  NUM_MICS*DELAY_W  committed delays; mic k at bits [k*DELAY_W +: DELAY_W]
- commit  out  1  one-cycle pulse in the cycle delay_flat takes a new bank
- cur_angle  out  SEL_W  angle of the committed bank
- busy  out  1  high in FETCH, DRAIN, WAIT_STROBE
- err_range  out  1  sticky; set when any fetched value exceeded MAX_DELAY

## Operation
- FSM states: IDLE, FETCH, DRAIN, WAIT_STROBE.
- IDLE
  - sel_valid & sel_ready → latch sel_angle as pending angle, go to FETCH.
  - Otherwise, if scan_en and dwell_cnt ≥ max(dwell,1) → pending = cur_angle+1 (NUM_ANGLES-1 wraps to 0), go to FETCH.
  - sel_valid has priority over scan in the same cycle.
- dwell_cnt (16-bit, saturating)
  - Cleared on every commit.
  - Incremented on each sample_strobe while in IDLE.
  - Does not count outside IDLE.
- FETCH: 16 cycles, mic index m = 0..15.
  - tbl_rd_en=1, tbl_addr = pending*NUM_MICS + m.
  - Data for read m is captured into shadow[m] in the following cycle.
  - After m=15, go to DRAIN.
- DRAIN: 1 cycle; captures shadow[15]; go to WAIT_STROBE.
- Clamp at capture: a value > MAX_DELAY is stored as MAX_DELAY and err_range is set. err_range clears only on reset.
- WAIT_STROBE
  - On sample_strobe=1: delay_flat ← shadow (all 16 at once), cur_angle ← pending, commit=1 next cycle, dwell_cnt ← 0, go to IDLE.
  - Otherwise hold.
- sample_strobe outside WAIT_STROBE does not commit and is not queued.
- sel_valid outside IDLE is held off (sel_ready=0). A new request is taken only after commit; no abort.
- scan_en deasserted mid-fetch does not abort the fetch; the fetched bank still commits.
- Reset (any time, including mid-FETCH)
  - State IDLE; shadow discarded.
  - delay_flat=0, cur_angle=0, commit=0, tbl_rd_en=0, tbl_addr=0, busy=0, err_range=0, dwell_cnt=0.
  - sel_ready=1 (IDLE).

## Timing
- Request accepted at edge E0 → tbl_rd_en high in cycles 1..16 after E0 → DRAIN in cycle 17 → WAIT_STROBE from cycle 18.
- Earliest commit:
  - New delay_flat, cur_angle and commit=1 are visible in cycle 19, when sample_strobe=1 in cycle 18.
  - Request-to-active latency is therefore 19 cycles plus the wait for a strobe.
- sel_ready returns to 1 in the same cycle commit is high; a back-to-back request can be accepted at that edge.
- Scan: with dwell=D, the next fetch starts on the first cycle after the D-th post-commit strobe seen in IDLE.
- All outputs are registered except sel_ready and busy, which decode state.

## Test plan
- Reset mid-FETCH (rst low at cycle 7 of fetch) → all outputs return to reset values immediately; sel_ready=1; a following request runs a full 16-read fetch from m=0.
- Request angle 3, table[3*16+k]=k, strobe every 40 cycles → tbl_addr 48..63 in consecutive cycles; commit high exactly once; delay_flat mic k = k (mic 15 clamped to 19 only if >19; here 15); cur_angle=3.
- Table value 25 at mic 7 → delay_flat mic7 = 19; err_range=1 and stays 1 across further commits.
- Strobes during FETCH/DRAIN → no commit; commit occurs on the first strobe in WAIT_STROBE, never earlier than cycle 19 after acceptance.
- scan_en=1, dwell=2, cur_angle=31 → after 2 strobes a fetch of angle 0 starts (tbl_addr 0..15); cur_angle wraps to 0 after commit. dwell=0 behaves as dwell=1.
- sel_valid (angle 9) and scan trigger in the same IDLE cycle → angle 9 fetched; sel_valid held during busy stays unaccepted until commit.

Source files
------------

// File: rtl/beam_steer_ctrl.sv
// beam_steer_ctrl
//   Sequencing controller for the microphone delay datapath. A steering
//   request (or the auto-scan timer) selects an angle. The controller reads
//   the NUM_MICS per-mic delays for that angle from an external coefficient
//   table into a shadow bank. It then swaps the whole bank onto delay_flat
//   on a PCM sample boundary, so the delay lines never see a mixed set.
//
// Ports
//   clk, rst        system clock; asynchronous active-low reset
//   sample_strobe   one-cycle PCM sample-boundary pulse
//   sel_valid/ready steering request handshake; sel_angle taken on accept
//   scan_en, dwell  auto-scan enable and samples per angle (0 acts as 1)
//   tbl_rd_en/addr  coefficient table read port (addr = angle*NUM_MICS+mic)
//   tbl_rd_data     table data, valid one cycle after tbl_rd_en
//   delay_flat      committed delays, mic k at [k*DELAY_W +: DELAY_W]
//   commit          one-cycle pulse when delay_flat takes a new bank
//   cur_angle       angle of the committed bank
//   busy            fetch / drain / waiting for a strobe
//   err_range       sticky flag: a fetched delay exceeded MAX_DELAY
module beam_steer_ctrl #(
  parameter  int NUM_MICS   = 16,
  parameter  int DELAY_W    = 5,
  parameter  int MAX_DELAY  = 19,
  parameter  int SEL_W      = 5,
  parameter  int NUM_ANGLES = 32,
  localparam int MIC_W      = $clog2(NUM_MICS),
  localparam int ADDR_W     = SEL_W + MIC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_strobe,
  input  logic                        sel_valid,
  input  logic [SEL_W-1:0]            sel_angle,
  output logic                        sel_ready,
  input  logic                        scan_en,
  input  logic [15:0]                 dwell,
  output logic                        tbl_rd_en,
  output logic [ADDR_W-1:0]           tbl_addr,
  input  logic [DELAY_W-1:0]          tbl_rd_data,
  output logic [NUM_MICS*DELAY_W-1:0] delay_flat,
  output logic                        commit,
  output logic [SEL_W-1:0]            cur_angle,
  output logic                        busy,
  output logic                        err_range
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_STROBE
  } state_t;

  state_t                    state;
  logic [SEL_W-1:0]          pending;
  logic [MIC_W-1:0]          mic_idx;
  logic                      cap_en;   // tbl_rd_data carries a requested word
  logic [MIC_W-1:0]          cap_idx;  // which mic that word belongs to
  logic [15:0]               dwell_cnt;
  logic [DELAY_W-1:0]        shadow [NUM_MICS];

  logic                      cap_over;
  logic [DELAY_W-1:0]        cap_val;
  logic                      scan_due;
  logic [SEL_W-1:0]          next_angle;
  logic                      start;
  logic [SEL_W-1:0]          start_angle;
  logic [NUM_MICS*DELAY_W-1:0] shadow_flat;

  assign sel_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cap_over    = 1'b0;
    cap_val     = tbl_rd_data;
    scan_due    = 1'b0;
    next_angle  = cur_angle + 1'b1;
    start       = 1'b0;
    start_angle = sel_angle;
    shadow_flat = '0;

    if (tbl_rd_data > DELAY_W'(MAX_DELAY)) begin
      cap_over = 1'b1;
      cap_val  = DELAY_W'(MAX_DELAY);
    end

    if (cur_angle == SEL_W'(NUM_ANGLES - 1)) next_angle = '0;

    // A dwell of zero behaves like one sample per angle.
    scan_due = scan_en && (dwell_cnt >= ((dwell == 16'd0) ? 16'd1 : dwell));

    // An explicit request wins over the scan timer in the same cycle.
    if (state == IDLE) begin
      start       = sel_valid || scan_due;
      start_angle = sel_valid ? sel_angle : next_angle;
    end

    for (int k = 0; k < NUM_MICS; k++) shadow_flat[k*DELAY_W +: DELAY_W] = shadow[k];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= '0;
      mic_idx    <= '0;
      cap_en     <= 1'b0;
      cap_idx    <= '0;
      dwell_cnt  <= '0;
      delay_flat <= '0;
      cur_angle  <= '0;
      commit     <= 1'b0;
      tbl_rd_en  <= 1'b0;
      tbl_addr   <= '0;
      err_range  <= 1'b0;
    end else begin
      commit  <= 1'b0;
      cap_en  <= tbl_rd_en;
      cap_idx <= mic_idx;

      if (cap_en && cap_over) err_range <= 1'b1;

      if (state == IDLE && sample_strobe && dwell_cnt != 16'hFFFF)
        dwell_cnt <= dwell_cnt + 16'd1;

      unique case (state)
        IDLE: begin
          if (start) begin
            pending   <= start_angle;
            mic_idx   <= '0;
            tbl_rd_en <= 1'b1;
            // NUM_MICS is a power of two, so angle*NUM_MICS+mic is a concat.
            tbl_addr  <= {start_angle, MIC_W'(0)};
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (mic_idx == MIC_W'(NUM_MICS - 1)) begin
            tbl_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            mic_idx  <= mic_idx + 1'b1;
            tbl_addr <= {pending, mic_idx + 1'b1};
          end
        end
        // The last word is still in flight; cap_en captures it this cycle.
        DRAIN: state <= WAIT_STROBE;
        WAIT_STROBE: begin
          if (sample_strobe) begin
            delay_flat <= shadow_flat;
            cur_angle  <= pending;
            commit     <= 1'b1;
            dwell_cnt  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the shadow bank has no reset; a fetch rewrites all entries before
  // the bank can be committed, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (cap_en) shadow[cap_idx] <= cap_val;
  end

endmodule

// File: tb/tb_beam_steer_ctrl.sv
// tb_beam_steer_ctrl
//   Self-checking bench for beam_steer_ctrl. A transaction-level reference
//   model tracks "cycles since the request was accepted". It predicts
//   outputs for each cycle from that count. Directed scenarios come first,
//   followed by a randomized run.
module tb_beam_steer_ctrl;
  localparam int NUM_MICS   = 16;
  localparam int DELAY_W    = 5;
  localparam int MAX_DELAY  = 19;
  localparam int SEL_W      = 5;
  localparam int NUM_ANGLES = 32;
  localparam int ADDR_W     = 9;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        sample_strobe;
  logic                        sel_valid;
  logic [SEL_W-1:0]            sel_angle;
  logic                        sel_ready;
  logic                        scan_en;
  logic [15:0]                 dwell;
  logic                        tbl_rd_en;
  logic [ADDR_W-1:0]           tbl_addr;
  logic [DELAY_W-1:0]          tbl_rd_data = '0;
  logic [NUM_MICS*DELAY_W-1:0] delay_flat;
  logic                        commit;
  logic [SEL_W-1:0]            cur_angle;
  logic                        busy;
  logic                        err_range;

  beam_steer_ctrl dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
    .sel_valid(sel_valid), .sel_angle(sel_angle), .sel_ready(sel_ready),
    .scan_en(scan_en), .dwell(dwell), .tbl_rd_en(tbl_rd_en),
    .tbl_addr(tbl_addr), .tbl_rd_data(tbl_rd_data), .delay_flat(delay_flat),
    .commit(commit), .cur_angle(cur_angle), .busy(busy), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Coefficient table: data appears one cycle after the read strobe.
  logic [DELAY_W-1:0] tbl [NUM_ANGLES*NUM_MICS];
  always @(posedge clk) if (tbl_rd_en) tbl_rd_data <= tbl[tbl_addr];

  // Reference model state.
  bit m_busy;
  int m_cyc;            // cycle index since acceptance (1 = first read)
  int m_pend, m_cur, m_dwell;
  int m_raw [NUM_MICS];
  int m_bank[NUM_MICS];
  int m_flat[NUM_MICS];
  bit m_commit, m_err;

  int n_checks = 0;
  int n_pass   = 0;
  int obs_commits = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_busy = 0; m_cyc = 0; m_pend = 0; m_cur = 0; m_dwell = 0;
    m_commit = 0; m_err = 0;
    for (int k = 0; k < NUM_MICS; k++) begin
      m_flat[k] = 0; m_bank[k] = 0; m_raw[k] = 0;
    end
  endfunction

  task automatic check_outputs();
    logic [NUM_MICS*DELAY_W-1:0] ef;
    bit exp_rd;
    for (int k = 0; k < NUM_MICS; k++) ef[k*DELAY_W +: DELAY_W] = m_flat[k][DELAY_W-1:0];
    exp_rd = m_busy && m_cyc >= 1 && m_cyc <= NUM_MICS;
    check("sel_ready", sel_ready, !m_busy);
    check("busy", busy, m_busy);
    check("tbl_rd_en", tbl_rd_en, exp_rd);
    if (exp_rd) check("tbl_addr", tbl_addr, m_pend * NUM_MICS + m_cyc - 1);
    check("commit", commit, m_commit);
    check("cur_angle", cur_angle, m_cur);
    check("delay_flat", delay_flat, ef);
    check("err_range", err_range, m_err);
    if (commit) obs_commits++;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_advance();
    bit take_sel, take_scan;
    int thr;
    m_commit = 0;
    if (!m_busy) begin
      thr       = (dwell == 0) ? 1 : int'(dwell);
      take_sel  = sel_valid;
      take_scan = !sel_valid && scan_en && (m_dwell >= thr);
      if (sample_strobe && m_dwell < 65535) m_dwell++;
      if (take_sel || take_scan) begin
        m_pend = take_sel ? int'(sel_angle) : (m_cur + 1) % NUM_ANGLES;
        for (int k = 0; k < NUM_MICS; k++) begin
          m_raw[k]  = tbl[m_pend * NUM_MICS + k];
          m_bank[k] = (m_raw[k] > MAX_DELAY) ? MAX_DELAY : m_raw[k];
        end
        m_busy = 1;
        m_cyc  = 1;
      end
    end else if (m_cyc >= NUM_MICS + 2 && sample_strobe) begin
      for (int k = 0; k < NUM_MICS; k++) m_flat[k] = m_bank[k];
      m_cur    = m_pend;
      m_commit = 1;
      m_dwell  = 0;
      m_busy   = 0;
    end else begin
      // Word for mic k is read in cycle k+1, captured at the end of k+2.
      if (m_cyc >= 2 && m_cyc <= NUM_MICS + 1 && m_raw[m_cyc-2] > MAX_DELAY) m_err = 1;
      m_cyc++;
    end
  endtask

  // One clock: check this cycle, apply inputs, step the model, next cycle.
  task automatic step(input bit s, input bit v, input int ang, input bit se, input int dw);
    check_outputs();
    sample_strobe = s;
    sel_valid     = v;
    sel_angle     = ang[SEL_W-1:0];
    scan_en       = se;
    dwell         = dw[15:0];
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_idle();
    for (int i = 0; i < 200 && m_busy; i++) step(i % 5 == 0, 0, 0, 0, 1);
    check("drain_idle", m_busy, 1'b0);
  endtask

  task automatic run_req(input int ang, input int period, input int ncyc);
    drain_idle();
    for (int i = 0; i < ncyc; i++) step(i % period == period - 1, i == 0, ang, 0, 1);
  endtask

  initial begin
    logic [NUM_MICS*DELAY_W-1:0] exp_flat;

    for (int i = 0; i < NUM_ANGLES * NUM_MICS; i++) tbl[i] = DELAY_W'($urandom_range(0, 31));
    for (int k = 0; k < NUM_MICS; k++) begin
      tbl[3*NUM_MICS + k] = DELAY_W'(k);
      tbl[5*NUM_MICS + k] = DELAY_W'(k % 10);
    end
    tbl[5*NUM_MICS + 7] = 5'd25;

    rst = 1'b0; sample_strobe = 0; sel_valid = 0; sel_angle = '0; scan_en = 0; dwell = 16'd1;
    model_reset();
    #2;
    check_outputs();
    check("rst_tbl_addr", tbl_addr, 0);
    @(negedge clk);
    rst = 1'b1;

    // Angle 3 with table[48+k]=k, strobe every 40 cycles: one commit.
    obs_commits = 0;
    run_req(3, 40, 60);
    for (int k = 0; k < NUM_MICS; k++) exp_flat[k*DELAY_W +: DELAY_W] = DELAY_W'(k);
    check("angle3_flat", delay_flat, exp_flat);
    check("angle3_cur", cur_angle, 3);
    check("angle3_commits", obs_commits, 1);
    check("angle3_err", err_range, 0);

    // Strobe every cycle: commit must still wait for WAIT_STROBE.
    run_req(6, 1, 25);

    // Out-of-range word at mic 7 is clamped and err_range sticks.
    run_req(5, 20, 45);
    check("clamp_mic7", delay_flat[7*DELAY_W +: DELAY_W], MAX_DELAY);
    check("err_set", err_range, 1);
    run_req(3, 20, 45);
    check("err_sticky", err_range, 1);

    // Scan from angle 31 wraps to 0, dwell=2, then dwell=0.
    run_req(31, 20, 45);
    check("scan_start_cur", cur_angle, 31);
    for (int i = 0; i < 80; i++) step(i % 10 == 5, 0, 0, 1, 2);
    drain_idle();
    for (int i = 0; i < 60; i++) step(i % 4 == 1, 0, 0, 1, 0);
    drain_idle();

    // sel_valid and scan trigger together; then a request held while busy.
    step(1, 0, 0, 0, 1);
    step(0, 1, 9, 1, 1);
    for (int i = 0; i < 50; i++) step(i % 7 == 3, 1, 12, 0, 1);
    drain_idle();

    // Asynchronous reset at cycle 7 of a fetch, then a full new fetch.
    step(0, 1, 20, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_mid_addr", tbl_addr, 0);
    #1;
    rst = 1'b1;
    run_req(21, 30, 40);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, NUM_ANGLES - 1), (i / 300) % 2 == 1,
           $urandom_range(0, 3));
    drain_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
